stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/stopwatch_ctrl_bcd_digit_counter.sv | 31 +++
 rtl/stopwatch_ctrl.sv | 136 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// Holds the FSM state enum, digit geometry and BCD limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_LAP,
        ST_STOP
    } state_t;

    localparam int unsigned NUM_DIGITS   = 4;
    localparam int unsigned IDX_W        = $clog2(NUM_DIGITS);
    localparam logic [3:0]  DIGIT_MAX    = 4'd9;
    localparam logic [3:0]  TENS_SEC_MAX = 4'd5;
    localparam int unsigned DP_INDEX     = 2;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_counter.sv
// Single BCD digit with synchronous clear, increment and carry-out.
// Carry is combinational so a chain of digits ripples within one edge.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX_VAL = DIGIT_MAX
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_inc,
    input  logic       i_clr,
    output logic [3:0] o_val,
    output logic       o_carry
);

    logic [3:0] r_val;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_val <= '0;
        end else if (i_clr) begin
            r_val <= '0;
        end else if (i_inc) begin
            r_val <= (r_val == MAX_VAL) ? '0 : r_val + 4'd1;
        end
    end

    assign o_carry = i_inc && (r_val == MAX_VAL);
    assign o_val   = r_val;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/lap/stop FSM, SS.hh BCD count with lap freeze,
// and a multiplexed 4-digit display scan with one-cycle decoder alignment.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       i_sys_clk,
    input  logic       i_reset_n,
    input  logic       i_start_stop,
    input  logic       i_lap,
    input  logic       i_clear,
    output logic [3:0] o_hex_out,
    output logic [3:0] o_digit_en,
    output logic       o_dp_out,
    output logic       o_running,
    output logic       o_wrap
);

    localparam int unsigned PW = $clog2(TICK_DIV + 1);
    localparam int unsigned SW = $clog2(SCAN_DIV + 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [PW-1:0]             r_presc;
    logic [SW-1:0]             r_scan;
    logic [IDX_W-1:0]          r_idx;
    logic [IDX_W-1:0]          r_hex_idx;
    logic                      r_hex_vld;
    logic [NUM_DIGITS*4-1:0]   r_lap;
    logic [3:0]                r_hex;
    logic [3:0]                r_digit_en;
    logic                      r_dp;
    logic                      r_wrap;
    logic [NUM_DIGITS*4-1:0]   w_count;
    logic [NUM_DIGITS*4-1:0]   w_disp;
    logic [NUM_DIGITS:0]       w_carry;
    logic                      w_run;
    logic                      w_presc_tc;
    logic                      w_tick;
    logic                      w_clr_cnt;
    logic                      w_lap_cap;

    assign w_run      = (r_state == ST_RUN) || (r_state == ST_LAP);
    assign w_presc_tc = (r_presc == PW'(TICK_DIV - 1));
    assign w_tick     = w_run && w_presc_tc;
    assign w_clr_cnt  = (r_state == ST_STOP) && i_clear;
    assign w_lap_cap  = (r_state == ST_RUN) && i_lap && !i_start_stop;

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    // start_stop dominates lap; clear dominates start_stop in STOP
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start_stop) w_state_nxt = ST_RUN;
            ST_RUN:  if (i_start_stop) w_state_nxt = ST_STOP;
                     else if (i_lap)   w_state_nxt = ST_LAP;
            ST_LAP:  if (i_start_stop) w_state_nxt = ST_STOP;
                     else if (i_lap)   w_state_nxt = ST_RUN;
            ST_STOP: if (i_clear)      w_state_nxt = ST_IDLE;
                     else if (i_start_stop) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n)     r_presc <= '0;
        else if (w_clr_cnt) r_presc <= '0;
        else if (w_run)     r_presc <= w_presc_tc ? '0 : r_presc + PW'(1);
    end

    assign w_carry[0] = w_tick;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_counter #(
            .MAX_VAL((g == NUM_DIGITS - 1) ? TENS_SEC_MAX : DIGIT_MAX)
        ) u_digit (
            .i_clk   (i_sys_clk),
            .i_rst_n (i_reset_n),
            .i_inc   (w_carry[g]),
            .i_clr   (w_clr_cnt),
            .o_val   (w_count[g*4 +: 4]),
            .o_carry (w_carry[g+1])
        );
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n)     r_lap <= '0;
        else if (w_lap_cap) r_lap <= w_count;
    end

    assign w_disp = (r_state == ST_LAP) ? r_lap : w_count;

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else if (r_scan == SW'(SCAN_DIV - 1)) begin
            r_scan <= '0;
            r_idx  <= r_idx + IDX_W'(1);
        end else begin
            r_scan <= r_scan + SW'(1);
        end
    end

    // Enables trail hex_out by one cycle to line up with the registered decoder
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hex      <= '0;
            r_hex_idx  <= '0;
            r_hex_vld  <= 1'b0;
            r_digit_en <= '0;
            r_dp       <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_hex      <= w_disp[{r_idx, 2'b00} +: 4];
            r_hex_idx  <= r_idx;
            r_hex_vld  <= 1'b1;
            r_digit_en <= r_hex_vld ? (4'b0001 << r_hex_idx) : '0;
            r_dp       <= r_hex_vld && (r_hex_idx == IDX_W'(DP_INDEX));
            r_wrap     <= w_carry[NUM_DIGITS];
        end
    end

    assign o_hex_out  = r_hex;
    assign o_digit_en = r_digit_en;
    assign o_dp_out   = r_dp;
    assign o_running  = w_run;
    assign o_wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random pulses,
// compared every cycle against an arithmetic centisecond model.
module tb_stopwatch_ctrl;

    localparam int unsigned TD = 4;
    localparam int unsigned SD = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss = 1'b0, lp = 1'b0, cl = 1'b0;
    logic [3:0] hex, en;
    logic       dp, run, wrap;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_DIV(TD),
        .SCAN_DIV(SD)
    ) dut (
        .i_sys_clk    (clk),
        .i_reset_n    (rst_n),
        .i_start_stop (ss),
        .i_lap        (lp),
        .i_clear      (cl),
        .o_hex_out    (hex),
        .o_digit_en   (en),
        .o_dp_out     (dp),
        .o_running    (run),
        .o_wrap       (wrap)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // model: count kept as plain centiseconds 0..5999
    int m_mode, m_cs, m_lap, m_presc, m_scan, m_idx, m_hidx;
    int m_hex, m_en, m_dp, m_wrap;
    bit m_hvld;

    logic [15:0] shown;
    logic [3:0]  prev_hex;

    function automatic int digit_of(input int v, input int i);
        case (i)
            0:       return v % 10;
            1:       return (v / 10) % 10;
            2:       return (v / 100) % 10;
            default: return v / 1000;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_cs = 0; m_lap = 0; m_presc = 0; m_scan = 0;
        m_idx = 0; m_hidx = 0; m_hvld = 1'b0;
        m_hex = 0; m_en = 0; m_dp = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit a_ss, input bit a_lp, input bit a_cl);
        int o_mode = m_mode;
        int o_cs   = m_cs;
        int o_lap  = m_lap;
        int o_idx  = m_idx;
        int o_hidx = m_hidx;
        bit o_hvld = m_hvld;
        bit counting = (o_mode == M_RUN) || (o_mode == M_LAP);
        bit tick = counting && (m_presc == TD - 1);
        bit do_clr = (o_mode == M_STOP) && a_cl;
        int disp;
        case (o_mode)
            M_IDLE: if (a_ss) m_mode = M_RUN;
            M_RUN:  if (a_ss) m_mode = M_STOP; else if (a_lp) m_mode = M_LAP;
            M_LAP:  if (a_ss) m_mode = M_STOP; else if (a_lp) m_mode = M_RUN;
            default: if (a_cl) m_mode = M_IDLE; else if (a_ss) m_mode = M_RUN;
        endcase
        if (counting)    m_presc = tick ? 0 : m_presc + 1;
        else if (do_clr) m_presc = 0;
        if (tick)   m_cs = (o_cs + 1) % 6000;
        if (do_clr) m_cs = 0;
        m_wrap = (tick && o_cs == 5999) ? 1 : 0;
        if (o_mode == M_RUN && a_lp && !a_ss) m_lap = o_cs;
        disp  = (o_mode == M_LAP) ? o_lap : o_cs;
        m_hex = digit_of(disp, o_idx);
        m_en  = o_hvld ? (1 << o_hidx) : 0;
        m_dp  = (o_hvld && o_hidx == 2) ? 1 : 0;
        m_hvld = 1'b1;
        m_hidx = o_idx;
        if (m_scan == SD - 1) begin
            m_scan = 0;
            m_idx  = (o_idx + 1) % 4;
        end else begin
            m_scan = m_scan + 1;
        end
    endtask

    task automatic compare_all();
        check("hex_out",  hex,  m_hex);
        check("digit_en", en,   m_en);
        check("dp_out",   dp,   m_dp);
        check("running",  run,  (m_mode == M_RUN || m_mode == M_LAP) ? 1 : 0);
        check("wrap",     wrap, m_wrap);
    endtask

    // one clock: drive pulses, model the edge, compare at the falling edge
    task automatic step(input bit a_ss, input bit a_lp, input bit a_cl);
        ss = a_ss; lp = a_lp; cl = a_cl;
        @(posedge clk);
        model_step(a_ss, a_lp, a_cl);
        @(negedge clk);
        compare_all();
        case (en)
            4'b0001: shown[3:0]   = prev_hex;
            4'b0010: shown[7:4]   = prev_hex;
            4'b0100: shown[11:8]  = prev_hex;
            4'b1000: shown[15:12] = prev_hex;
            default: ;
        endcase
        prev_hex = hex;
        ss = 1'b0; lp = 1'b0; cl = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic capture(input int n);
        shown = '1;
        idle(n);
    endtask

    task automatic run_until(input int target, input int budget);
        for (int i = 0; i < budget && m_cs != target; i++) step(1'b0, 1'b0, 1'b0);
        check("reach_count", m_cs, target);
    endtask

    // reset lands between edges so the asynchronous clear is observable
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_hex",  hex,  0);
        check("rst_en",   en,   0);
        check("rst_dp",   dp,   0);
        check("rst_run",  run,  0);
        check("rst_wrap", wrap, 0);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        prev_hex = '0;
    endtask

    int wraps;

    initial begin
        shown = '1;
        prev_hex = '0;
        model_reset();
        @(negedge clk);

        // first enable two edges after release
        do_reset();
        step(0, 0, 0);
        check("en_edge1", en, 4'b0000);
        step(0, 0, 0);
        check("en_edge2", en, 4'b0001);

        // 40 cycles of RUN from zero
        do_reset();
        step(1, 0, 0);
        idle(40);
        check("run_after_40", run, 1);
        check("model_cs_40", m_cs, 10);
        step(1, 0, 0);
        capture(12);
        check("disp_00_10", shown, 16'h0010);

        // pause with prescaler at 2, resume keeps the phase
        do_reset();
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        check("model_presc_2", m_presc, 2);
        idle(5);
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        capture(12);
        check("disp_resume_tick", shown, 16'h0001);

        // clear beats start_stop in STOP
        do_reset();
        step(1, 0, 0);
        run_until(7, 200);
        step(1, 0, 0);
        capture(12);
        check("disp_00_07", shown, 16'h0007);
        step(1, 0, 1);
        check("idle_after_clear", run, 0);
        capture(12);
        check("disp_cleared", shown, 16'h0000);

        // lap freezes display while count continues
        do_reset();
        step(1, 0, 0);
        run_until(5, 200);
        step(0, 1, 0);
        check("run_in_lap", run, 1);
        idle(70);
        capture(10);
        check("disp_lap_frozen", shown, 16'h0005);
        check("model_cs_25", m_cs, 25);
        step(0, 1, 0);
        step(1, 0, 0);
        capture(12);
        check("disp_after_release", shown, 16'h0025);

        // rollover 59.99 -> 00.00
        do_reset();
        step(1, 0, 0);
        run_until(5998, 30000);
        wraps = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0);
            if (wrap) wraps++;
        end
        check("wrap_pulses", wraps, 1);
        check("model_cs_wrapped", m_cs, 0);
        step(1, 0, 0);
        capture(12);
        check("disp_wrapped", shown, 16'h0000);

        // reset in LAP at 12.34
        do_reset();
        step(1, 0, 0);
        run_until(1234, 6000);
        step(0, 1, 0);
        idle(5);
        do_reset();
        step(0, 0, 0);
        check("en_edge1_lap_rst", en, 4'b0000);
        step(0, 0, 0);
        check("en_edge2_lap_rst", en, 4'b0001);
        capture(12);
        check("disp_after_lap_rst", shown, 16'h0000);

        // random pulse traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 14) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
